// File: rtl/stopwatch_up.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_up
// Brief    : Count-up MM:SS BCD stopwatch (00:00..99:59) with key handling,
//            1 Hz tick divider and run/pause/lap FSM. Lap feature: STOPWATCH_LAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module stopwatch_up #(
  parameter int CLK_HZ = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_stop_n,
  input  logic       lap_n,
  input  logic       clear_n,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       lap_active,
  output logic       overflow
);

  localparam int              DIV_W    = $clog2(CLK_HZ);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_HZ - 1);
  localparam logic [15:0]     CNT_MAX  = 16'h9959;

`ifdef STOPWATCH_LAP_EN
  localparam int KEY_W = 3;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_PAUSE = 3'd2,
    S_OVF   = 3'd3,
    S_LAP   = 3'd4
  } state_t;
`else
  localparam int KEY_W = 2;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_OVF   = 2'd3
  } state_t;
`endif

  // Asynchronous assert, two-flop synchronous release
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  logic [KEY_W-1:0] key_raw;
  logic [KEY_W-1:0] key_s1_q, key_s2_q, key_prev_q;
  logic [KEY_W-1:0] press_q, press_d;
  logic             press_clear, press_start;

`ifdef STOPWATCH_LAP_EN
  logic press_lap;
  assign key_raw   = {clear_n, start_stop_n, lap_n};
  assign press_lap = press_q[0];
`else
  logic unused_lap;
  assign key_raw    = {clear_n, start_stop_n};
  assign unused_lap = lap_n;
`endif

  assign press_d     = key_prev_q & ~key_s2_q;
  assign press_clear = press_q[KEY_W-1];
  assign press_start = press_q[KEY_W-2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_s1_q   <= '1;
      key_s2_q   <= '1;
      key_prev_q <= '1;
      press_q    <= '0;
    end else begin
      key_s1_q   <= key_raw;
      key_s2_q   <= key_s1_q;
      key_prev_q <= key_s2_q;
      press_q    <= press_d;
    end
  end

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [15:0]      cnt_q, cnt_d, cnt_inc;
  logic [15:0]      disp_q, disp_d;
  logic             running_q, running_d;
  logic             lap_active_q, lap_active_d;
  logic             overflow_q, overflow_d;
  logic             counting, tick;
`ifdef STOPWATCH_LAP_EN
  logic [15:0]      lap_q, lap_d;
`endif

  always_comb begin
    counting = (state_q == S_RUN);
`ifdef STOPWATCH_LAP_EN
    if (state_q == S_LAP) counting = 1'b1;
`endif
  end

  // BCD increment, digits {min_tens, min_ones, sec_tens, sec_ones}
  always_comb begin
    cnt_inc = cnt_q;
    if (cnt_q[3:0] != 4'd9) begin
      cnt_inc[3:0] = cnt_q[3:0] + 4'd1;
    end else begin
      cnt_inc[3:0] = 4'd0;
      if (cnt_q[7:4] != 4'd5) begin
        cnt_inc[7:4] = cnt_q[7:4] + 4'd1;
      end else begin
        cnt_inc[7:4] = 4'd0;
        if (cnt_q[11:8] != 4'd9) begin
          cnt_inc[11:8] = cnt_q[11:8] + 4'd1;
        end else begin
          cnt_inc[11:8]  = 4'd0;
          cnt_inc[15:12] = cnt_q[15:12] + 4'd1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef STOPWATCH_LAP_EN
    lap_d   = lap_q;
`endif
    tick = counting && (div_q == DIV_LAST);
    if (counting)                div_d = tick ? '0 : div_q + DIV_W'(1);
    else if (state_q == S_PAUSE) div_d = div_q;
    else                         div_d = '0;
    if (tick) cnt_d = cnt_inc;

    case (state_q)
      S_IDLE: begin
        if (!press_clear && press_start) state_d = S_RUN;
      end
      S_RUN: begin
        if (press_start) state_d = S_PAUSE;
`ifdef STOPWATCH_LAP_EN
        else if (press_lap) begin
          state_d = S_LAP;
          lap_d   = cnt_q;
        end
`endif
      end
`ifdef STOPWATCH_LAP_EN
      S_LAP: begin
        if (press_start)    state_d = S_PAUSE;
        else if (press_lap) lap_d   = cnt_q;
      end
`endif
      S_PAUSE: begin
        if (press_clear) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          div_d   = '0;
        end else if (press_start) begin
          state_d = S_RUN;
        end
      end
      S_OVF: begin
        if (press_clear) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Saturation overrides any key decision in the same cycle
    if (tick && (cnt_q == CNT_MAX)) begin
      state_d = S_OVF;
      cnt_d   = cnt_q;
    end

    disp_d       = cnt_d;
    running_d    = (state_d == S_RUN);
    lap_active_d = 1'b0;
    overflow_d   = (state_d == S_OVF);
`ifdef STOPWATCH_LAP_EN
    if (state_d == S_LAP) begin
      disp_d       = lap_d;
      running_d    = 1'b1;
      lap_active_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      div_q        <= '0;
      cnt_q        <= '0;
      disp_q       <= '0;
      running_q    <= 1'b0;
      lap_active_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      cnt_q        <= cnt_d;
      disp_q       <= disp_d;
      running_q    <= running_d;
      lap_active_q <= lap_active_d;
      overflow_q   <= overflow_d;
    end
  end

`ifdef STOPWATCH_LAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lap_q <= '0;
    else        lap_q <= lap_d;
  end
`endif

  assign sec_ones   = disp_q[3:0];
  assign sec_tens   = disp_q[7:4];
  assign min_ones   = disp_q[11:8];
  assign min_tens   = disp_q[15:12];
  assign running    = running_q;
  assign lap_active = lap_active_q;
  assign overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_up.sv
`default_nettype none
// ============================================================================
// Module   : tb_stopwatch_up
// Brief    : Directed, table-driven bench for stopwatch_up at CLK_HZ=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stopwatch_up;
  localparam int CLK_HZ = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_stop_n = 1'b1;
  logic       lap_n = 1'b1;
  logic       clear_n = 1'b1;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic       running, lap_active, overflow;

  int tests = 0;
  int fails = 0;

  stopwatch_up #(.CLK_HZ(CLK_HZ)) dut (
    .clk          (clk),
    .reset        (reset),
    .start_stop_n (start_stop_n),
    .lap_n        (lap_n),
    .clear_n      (clear_n),
    .sec_ones     (sec_ones),
    .sec_tens     (sec_tens),
    .min_ones     (min_ones),
    .min_tens     (min_tens),
    .running      (running),
    .lap_active   (lap_active),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  typedef enum int {A_NONE, A_START, A_LAP, A_CLEAR, A_CLR_START} act_e;
  typedef struct {
    act_e        act;
    int          wait_cyc;
    logic [15:0] disp;
    logic        run;
    logic        lap;
    logic        ovf;
  } vec_t;

  vec_t vq[$];

  task automatic add(input act_e a, input int w, input logic [15:0] d,
                     input logic r, input logic l, input logic o);
    vec_t v;
    v.act = a; v.wait_cyc = w; v.disp = d; v.run = r; v.lap = l; v.ovf = o;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [15:0] ed,
                       input logic er, input logic el, input logic eo);
    logic [15:0] got;
    got = {min_tens, min_ones, sec_tens, sec_ones};
    tests++;
    if (got !== ed || running !== er || lap_active !== el || overflow !== eo) begin
      fails++;
      $display("FAIL %s: got %h run=%b lap=%b ovf=%b, expected %h run=%b lap=%b ovf=%b",
               name, got, running, lap_active, overflow, ed, er, el, eo);
    end
  endtask

  // One-cycle key press; returns just after the edge where the state updates
  task automatic press(input logic s, input logic l, input logic c);
    start_stop_n = ~s;
    lap_n        = ~l;
    clear_n      = ~c;
    @(negedge clk);
    start_stop_n = 1'b1;
    lap_n        = 1'b1;
    clear_n      = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic apply(input act_e a);
    case (a)
      A_START:     press(1'b1, 1'b0, 1'b0);
      A_LAP:       press(1'b0, 1'b1, 1'b0);
      A_CLEAR:     press(1'b0, 1'b0, 1'b1);
      A_CLR_START: press(1'b1, 1'b0, 1'b1);
      default:     ;
    endcase
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got time limit, expected bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Times in comments are cycles since the state-changing edge of the last start press
    add(A_NONE,      0,    16'h0000, 0, 0, 0);
    add(A_START,     0,    16'h0000, 1, 0, 0);
    add(A_NONE,      3,    16'h0000, 1, 0, 0);  // t=3, just before first tick
    add(A_NONE,      1,    16'h0001, 1, 0, 0);  // t=4
    add(A_NONE,      32,   16'h0009, 1, 0, 0);  // t=36
    add(A_NONE,      4,    16'h0010, 1, 0, 0);  // t=40
    add(A_NONE,      196,  16'h0059, 1, 0, 0);
    add(A_NONE,      4,    16'h0100, 1, 0, 0);
    add(A_NONE,      2156, 16'h0959, 1, 0, 0);
    add(A_NONE,      4,    16'h1000, 1, 0, 0);
    add(A_NONE,      2,    16'h1000, 1, 0, 0);  // t=2402
    add(A_START,     0,    16'h1001, 0, 0, 0);  // pause, divider held at 2
    add(A_NONE,      20,   16'h1001, 0, 0, 0);
    add(A_START,     0,    16'h1001, 1, 0, 0);  // resume
    add(A_NONE,      1,    16'h1001, 1, 0, 0);
    add(A_NONE,      1,    16'h1002, 1, 0, 0);  // 2 cycles after resume
    add(A_CLEAR,     0,    16'h1003, 1, 0, 0);  // clear ignored in RUN
    add(A_START,     0,    16'h1004, 0, 0, 0);
    add(A_CLR_START, 0,    16'h0000, 0, 0, 0);  // clear wins
    add(A_LAP,       0,    16'h0000, 0, 0, 0);  // lap ignored in IDLE
    add(A_START,     0,    16'h0000, 1, 0, 0);
`ifdef STOPWATCH_LAP_EN
    add(A_LAP,       0,    16'h0000, 1, 1, 0);  // captures pre-increment value
    add(A_NONE,      8,    16'h0000, 1, 1, 0);
    add(A_LAP,       0,    16'h0003, 1, 1, 0);  // re-capture
`else
    add(A_LAP,       0,    16'h0001, 1, 0, 0);
    add(A_NONE,      8,    16'h0003, 1, 0, 0);
    add(A_LAP,       0,    16'h0004, 1, 0, 0);
`endif
    add(A_START,     0,    16'h0005, 0, 0, 0);
    add(A_LAP,       0,    16'h0005, 0, 0, 0);  // lap ignored in PAUSE
    add(A_CLEAR,     0,    16'h0000, 0, 0, 0);
    add(A_START,     0,    16'h0000, 1, 0, 0);
    add(A_NONE,      23996, 16'h9959, 1, 0, 0);
    add(A_NONE,      3,    16'h9959, 1, 0, 0);
    add(A_NONE,      1,    16'h9959, 0, 0, 1);  // saturate
    add(A_NONE,      2,    16'h9959, 0, 0, 1);
    add(A_START,     0,    16'h9959, 0, 0, 1);
    add(A_LAP,       0,    16'h9959, 0, 0, 1);
    add(A_CLEAR,     0,    16'h0000, 0, 0, 0);

    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", 16'h0000, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < vq.size(); i++) begin
      apply(vq[i].act);
      repeat (vq[i].wait_cyc) @(negedge clk);
      check($sformatf("vec%0d", i), vq[i].disp, vq[i].run, vq[i].lap, vq[i].ovf);
    end

    // Held start key must give one press only
    start_stop_n = 1'b0;
    repeat (12) @(negedge clk);
    start_stop_n = 1'b1;
    check("held_key", 16'h0002, 1'b1, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    check("held_key_no_toggle", 16'h0003, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset mid-run, checked before any clock edge
    #3 reset = 1'b0;
    #1 check("reset_async", 16'h0000, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("reset_release", 16'h0000, 1'b0, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    check("restart", 16'h0000, 1'b1, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    check("restart_tick", 16'h0001, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
